// File: rtl/sqed_mem_pkg.sv
// rtl/sqed_mem_pkg.sv - shared types and constants for the SQED memory bridge
package sqed_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Source of mem_rdata during and after a response.
    typedef enum logic [1:0] {
        RSEL_ZERO,
        RSEL_ARRAY,
        RSEL_OOR
    } rsel_e;

    localparam logic [31:0] OOR_RDATA_DEFAULT = 32'h0000_0013;
    localparam int          CNT_W             = 16;

endpackage

// File: rtl/sqed_mem_array.sv
// rtl/sqed_mem_array.sv - single-port byte-writable RAM, synchronous read-before-write
module sqed_mem_array #(
    parameter int WORDS = 32,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    // Read returns the word as it was before this edge's byte writes land.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem_q[addr];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sqed_mem_bridge.sv
// rtl/sqed_mem_bridge.sv - picorv32 native memory slave with wait states, range check and counters
module sqed_mem_bridge
    import sqed_mem_pkg::*;
#(
    parameter int          WORDS       = 32,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] OOR_RDATA   = OOR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        oob_err,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    localparam int AW = $clog2(WORDS);

    state_e           state_q, state_d;
    logic [3:0]       stall_q, stall_d;
    logic [29:0]      idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             instr_q, instr_d;
    logic             ready_q, ready_d;
    rsel_e            rsel_q, rsel_d;
    logic             oob_q, oob_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             fire;
    logic             in_range;
    logic             arr_en;
    logic [31:0]      arr_rdata;
    logic             unused_bits;

    // fire marks the edge that enters RESP; the access uses the request as it
    // will be captured on that same edge, so zero-wait requests skip a cycle.
    always_comb begin
        state_d  = state_q;
        stall_d  = stall_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        instr_d  = instr_q;
        ready_d  = 1'b0;
        rsel_d   = rsel_q;
        oob_d    = oob_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        fire     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    idx_d   = mem_addr[31:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        stall_d = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = RESP;
                        fire    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (stall_q == 4'd0) begin
                    state_d = RESP;
                    fire    = 1'b1;
                end else begin
                    stall_d = stall_q - 4'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_range = (idx_d[29:AW] == '0);

        if (fire) begin
            ready_d = 1'b1;
            if (in_range) begin
                rsel_d = RSEL_ARRAY;
            end else begin
                rsel_d = RSEL_OOR;
                oob_d  = 1'b1;
            end
            if (wstrb_d != 4'b0000) begin
                if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            stall_q  <= 4'd0;
            idx_q    <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            instr_q  <= 1'b0;
            ready_q  <= 1'b0;
            rsel_q   <= RSEL_ZERO;
            oob_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            stall_q  <= stall_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            instr_q  <= instr_d;
            ready_q  <= ready_d;
            rsel_q   <= rsel_d;
            oob_q    <= oob_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // An edge that sees reset must not let the RAM complete a write.
    assign arr_en = fire & in_range & ~reset;

    sqed_mem_array #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (wstrb_d),
        .addr  (idx_d[AW-1:0]),
        .wdata (wdata_d),
        .rdata (arr_rdata)
    );

    always_comb begin
        mem_rdata = 32'h0;
        case (rsel_q)
            RSEL_ARRAY: mem_rdata = arr_rdata;
            RSEL_OOR:   mem_rdata = OOR_RDATA;
            default:    mem_rdata = 32'h0;
        endcase
    end

    assign mem_ready   = ready_q;
    assign oob_err     = oob_q;
    assign rd_cnt      = rd_cnt_q;
    assign wr_cnt      = wr_cnt_q;
    assign unused_bits = ^{mem_addr[1:0], instr_q};

endmodule

// File: tb/tb_sqed_mem_bridge.sv
// tb/tb_sqed_mem_bridge.sv - directed table-driven bench for sqed_mem_bridge (0 and 3 wait states)
module tb_sqed_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  valid;
    logic [1:0]  instr;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  ready;
    logic [31:0] rdata [2];
    logic [1:0]  oob;
    logic [15:0] rdc   [2];
    logic [15:0] wrc   [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sqed_mem_bridge #(.WORDS(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_valid(valid[0]), .mem_instr(instr[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
        .mem_ready(ready[0]), .mem_rdata(rdata[0]), .oob_err(oob[0]),
        .rd_cnt(rdc[0]), .wr_cnt(wrc[0])
    );

    sqed_mem_bridge #(.WORDS(32), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .mem_valid(valid[1]), .mem_instr(instr[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
        .mem_ready(ready[1]), .mem_rdata(rdata[1]), .oob_err(oob[1]),
        .rd_cnt(rdc[1]), .wr_cnt(wrc[1])
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_oob;
        logic [15:0] exp_rdc;
        logic [15:0] exp_wrc;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        @(negedge clk);
        valid[d] = 1'b1;
        instr[d] = (ws == 4'b0000);
        addr[d]  = a;
        wdata[d] = wd;
        wstrb[d] = ws;
    endtask

    // First edge is the sampling edge; lat counts further edges until mem_ready.
    task automatic complete(input int d, output logic [31:0] rd, output int lat);
        @(posedge clk);
        lat = 0;
        #1;
        while (ready[d] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd       = rdata[d];
        valid[d] = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("ready_drop_d%0d", d), {31'b0, ready[d]}, 32'h0);
    endtask

    task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rd, output int lat);
        drive(d, a, wd, ws);
        complete(d, rd, lat);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;

        tbl[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,          1'b0, 16'd0, 16'd1};
        tbl[1]  = '{32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 16'd1, 16'd1};
        tbl[2]  = '{32'h0000_0000, 32'h1122_3344, 4'hF, 1'b0, 32'h0,          1'b0, 16'd1, 16'd2};
        tbl[3]  = '{32'h0000_0000, 32'hAABB_CCDD, 4'h5, 1'b1, 32'h1122_3344, 1'b0, 16'd1, 16'd3};
        tbl[4]  = '{32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD, 1'b0, 16'd2, 16'd3};
        tbl[5]  = '{32'h0000_0080, 32'h0,         4'h0, 1'b1, 32'h0000_0013, 1'b1, 16'd3, 16'd3};
        tbl[6]  = '{32'h0000_0080, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0013, 1'b1, 16'd3, 16'd4};
        tbl[7]  = '{32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD, 1'b1, 16'd4, 16'd4};
        tbl[8]  = '{32'h8000_0010, 32'h0,         4'h0, 1'b1, 32'h0000_0013, 1'b1, 16'd5, 16'd4};
        tbl[9]  = '{32'h0000_007C, 32'h1234_5678, 4'hF, 1'b0, 32'h0,          1'b1, 16'd5, 16'd5};
        tbl[10] = '{32'h0000_007F, 32'h0,         4'h0, 1'b1, 32'h1234_5678, 1'b1, 16'd6, 16'd5};

        reset = 1'b1;
        valid = 2'b00;
        instr = 2'b00;
        for (int d = 0; d < 2; d++) begin
            addr[d]  = 32'h0;
            wdata[d] = 32'h0;
            wstrb[d] = 4'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready_d%0d", d), {31'b0, ready[d]}, 32'h0);
            chk($sformatf("rst_rdata_d%0d", d), rdata[d], 32'h0);
            chk($sformatf("rst_oob_d%0d", d), {31'b0, oob[d]}, 32'h0);
            chk($sformatf("rst_rdcnt_d%0d", d), {16'b0, rdc[d]}, 32'h0);
            chk($sformatf("rst_wrcnt_d%0d", d), {16'b0, wrc[d]}, 32'h0);
        end
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            access(0, tbl[i].a, tbl[i].wd, tbl[i].ws, rd, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd0);
            if (tbl[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("v%0d_oob", i), {31'b0, oob[0]}, {31'b0, tbl[i].exp_oob});
            chk($sformatf("v%0d_rdcnt", i), {16'b0, rdc[0]}, {16'b0, tbl[i].exp_rdc});
            chk($sformatf("v%0d_wrcnt", i), {16'b0, wrc[0]}, {16'b0, tbl[i].exp_wrc});
        end

        // Saturation: preload the read counter near its ceiling, then keep reading.
        @(negedge clk);
        force dut0.rd_cnt_q = 16'hFFFD;
        #1;
        release dut0.rd_cnt_q;
        access(0, 32'h0, 32'h0, 4'h0, rd, lat);
        chk("sat_rdcnt_1", {16'b0, rdc[0]}, 32'h0000_FFFE);
        access(0, 32'h0, 32'h0, 4'h0, rd, lat);
        chk("sat_rdcnt_2", {16'b0, rdc[0]}, 32'h0000_FFFF);
        access(0, 32'h0, 32'h0, 4'h0, rd, lat);
        chk("sat_rdcnt_3", {16'b0, rdc[0]}, 32'h0000_FFFF);
        chk("sat_wrcnt", {16'b0, wrc[0]}, 32'h0000_0005);

        access(1, 32'h0000_0004, 32'hCAFE_F00D, 4'hF, rd, lat);
        chk("w3_write_latency", 32'(lat), 32'd3);
        access(1, 32'h0000_0004, 32'h0, 4'h0, rd, lat);
        chk("w3_read_latency", 32'(lat), 32'd3);
        chk("w3_read_rdata", rd, 32'hCAFE_F00D);
        access(1, 32'h0000_0008, 32'h55AA_55AA, 4'hF, rd, lat);
        chk("w3_pre_wrcnt", {16'b0, wrc[1]}, 32'd2);

        // Reset lands while a write to 0x8 is stalled in WAIT.
        drive(1, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk);
        #1;
        chk("mid_ready_wait", {31'b0, ready[1]}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_wrcnt", {16'b0, wrc[1]}, 32'h0);
        chk("mid_rst_rdcnt", {16'b0, rdc[1]}, 32'h0);
        chk("mid_rst_oob", {31'b0, oob[1]}, 32'h0);
        wstrb[1] = 4'h0;
        instr[1] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_ready", {31'b0, ready[1]}, 32'h0);
        end
        reset = 1'b0;
        complete(1, rd, lat);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_rdata", rd, 32'h55AA_55AA);
        chk("post_rst_rdcnt", {16'b0, rdc[1]}, 32'd1);
        chk("post_rst_wrcnt", {16'b0, wrc[1]}, 32'd0);
        chk("post_rst_oob", {31'b0, oob[1]}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sqed_mem_bridge.md
# sqed_mem_bridge

Parametrised single-port memory slave for the picorv32 native memory interface in the SQED demo top. Replaces the fixed 32-word, always-ready memory with a handshaked bridge that has configurable depth, programmable wait states, out-of-range detection and access counters. It lets the checker run the core against both zero-latency and stalled memory.

## Interface

- WORDS, 32: number of 32-bit words; power of two, 4..4096; AW = $clog2(WORDS).
- WAIT_CYCLES, 0: extra stall cycles inserted per access; 0..15.
- OOR_RDATA, 32'h0000_0013: read data returned for out-of-range reads (RV32 NOP).
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_valid  input  1  request from core; held with addr/wdata/wstrb until mem_ready.
- mem_instr  input  1  request is an instruction fetch.
- mem_addr  input  32  byte address; bits [1:0] ignored.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte enables; 4'b0000 = read.
- mem_ready  output  1  one-cycle completion pulse; registered.
- mem_rdata  output  32  read data; valid while mem_ready=1; registered.
- oob_err  output  1  sticky; set by any out-of-range access.
- rd_cnt  output  16  completed reads (incl. fetches), saturating at 16'hFFFF.
- wr_cnt  output  16  completed writes, saturating at 16'hFFFF.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: on mem_valid=1, capture addr word index (mem_addr[31:2]), wdata, wstrb, instr into request registers. Go to WAIT if WAIT_CYCLES>0 (load stall counter with WAIT_CYCLES-1), else RESP.
- WAIT: decrement stall counter; at 0 go to RESP.
- Entry into RESP (same edge): perform access, register mem_rdata, set mem_ready=1, update counters/oob_err.
- RESP: lasts exactly one cycle; next state IDLE unconditionally; mem_ready returns to 0.
- In range: captured word index < WORDS (all of addr[31:AW+2] zero).
- In-range read: mem_rdata = array[index].
- In-range write: for each set wstrb[i], array[index] byte i <= wdata byte i; mem_rdata = old word (read-before-write).
- Out of range: writes dropped, mem_rdata = OOR_RDATA, oob_err <= 1; counters still increment.
- Counters: wstrb≠0 → wr_cnt+1, else rd_cnt+1; hold at 16'hFFFF.
- mem_valid dropped during WAIT (protocol violation): transaction completes from captured values; mem_ready still pulses.
- Input changes after capture are ignored until the next IDLE sample.

## Timing

- Request sampled in IDLE at edge t → mem_ready high in cycle t+1+WAIT_CYCLES, for exactly one cycle.
- Back-to-back: next request sampled no earlier than the edge ending RESP; min throughput one access per 2+WAIT_CYCLES cycles.
- Reset (async, any state incl. WAIT/RESP): state=IDLE, mem_ready=0, mem_rdata=0, oob_err=0, rd_cnt=0, wr_cnt=0, stall counter=0; in-flight access abandoned with no write and no counter update. Memory array not reset; contents preserved.
- Reset deasserted with mem_valid=1: request sampled on first edge after deassertion.

## Structure

- Package sqed_mem_pkg: FSM state enum (IDLE/WAIT/RESP), default OOR_RDATA constant, counter width constant (16).
- Sub-module sqed_mem_array: WORDS×32 byte-writable RAM, one port, synchronous read-before-write, no reset; enable driven only on entry into RESP with in-range index.
- Top holds FSM, request registers, stall counter, range check, counters, oob_err.

## Test plan

- WAIT_CYCLES=0: write 32'hDEADBEEF, wstrb 4'hF to 0x10, then read 0x10 → mem_ready 1 cycle after each sample, rdata 32'hDEADBEEF, wr_cnt=1, rd_cnt=1.
- Byte strobes: preload 0x0 with 32'h11223344, write 32'hAABBCCDD wstrb 4'b0101 → read 0x0 returns 32'h11BB33DD.
- WAIT_CYCLES=3: read 0x4 sampled at edge t → mem_ready exactly at cycle t+4, low at t+1..t+3 and t+5.
- WORDS=32: read 0x80 → rdata 32'h00000013, oob_err=1 and stays 1; write 32'hFFFFFFFF to 0x80 then read 0x0 unchanged.
- Reset asserted during WAIT of a write to 0x8 (WAIT_CYCLES=2) → mem_ready never pulses, word 0x8 unchanged, wr_cnt=0, oob_err=0, FSM accepts new read immediately after release.
- Counter saturation: force 65537 reads → rd_cnt=16'hFFFF, wr_cnt unchanged.
